// File: rtl/alu_exec_if.sv
// Handshake bundle between the register-read stage, alu_exec and writeback.
// The master drives the operation and accepts results; alu_exec is the slave.
interface alu_exec_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       aluoper;
   logic [WIDTH-1:0] srca;
   logic [WIDTH-1:0] srcb;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             ovf;
   logic             illegal;

   modport master (
      output in_valid, aluoper, srca, srcb, out_ready,
      input  in_ready, out_valid, result, zero, ovf, illegal
   );

   modport slave (
      input  in_valid, aluoper, srca, srcb, out_ready,
      output in_ready, out_valid, result, zero, ovf, illegal
   );
endinterface

// File: rtl/alu_exec.sv
// Two-stage pipelined ALU: S1 registers the operation and operands, S2
// computes and registers the result and flags. Valid/ready on both sides,
// one op per cycle, two ops buffered under back-pressure.
module alu_exec #(
   parameter int WIDTH = 32
) (
   input logic       clk,
   input logic       rst,
   alu_exec_if.slave bus
);
   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   logic             v1_reg;
   logic             v2_reg;
   logic [2:0]       op_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] result_reg;
   logic             zero_reg;
   logic             ovf_reg;
   logic             illegal_reg;

   logic [WIDTH-1:0] result_next;
   logic             ovf_next;
   logic             illegal_next;

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic             ovf_add;
   logic             ovf_sub;
   logic             adv1;
   logic             adv2;

   // S2 may load whenever it is empty or its current content leaves this cycle;
   // S1 may load whenever it is empty or it hands its content to S2.
   assign adv2         = v1_reg && (!v2_reg || bus.out_ready);
   assign bus.in_ready = !v1_reg || adv2;
   assign adv1         = bus.in_valid && bus.in_ready;

   // Wrap-around arithmetic; the carry-out is simply dropped.
   assign sum  = a_reg + b_reg;
   assign diff = a_reg + ~b_reg + {{(WIDTH-1){1'b0}}, 1'b1};

   assign ovf_add = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (sum[WIDTH-1]  != a_reg[WIDTH-1]);
   assign ovf_sub = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (diff[WIDTH-1] != a_reg[WIDTH-1]);

   // Result and flag selection from the S1 contents.
   always_comb begin
      result_next  = '0;
      ovf_next     = 1'b0;
      illegal_next = 1'b0;
      case (op_reg)
         OP_ADD: begin
            result_next = sum;
            ovf_next    = ovf_add;
         end
         OP_SUB: begin
            result_next = diff;
            ovf_next    = ovf_sub;
         end
         OP_AND: result_next = a_reg & b_reg;
         OP_OR:  result_next = a_reg | b_reg;
         // Signed less-than: the sign of the difference, corrected when it overflowed.
         OP_SLT: result_next = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ ovf_sub};
         default: illegal_next = 1'b1;
      endcase
   end

   // S1: capture a new op on an input transfer, empty when handed on to S2.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_reg <= 1'b0;
         op_reg <= '0;
         a_reg  <= '0;
         b_reg  <= '0;
      end else begin
         if (adv1) begin
            v1_reg <= 1'b1;
            op_reg <= bus.aluoper;
            a_reg  <= bus.srca;
            b_reg  <= bus.srcb;
         end else if (adv2) begin
            v1_reg <= 1'b0;
         end
      end
   end

   // S2: register outputs only on advance so they stay put while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         v2_reg      <= 1'b0;
         result_reg  <= '0;
         zero_reg    <= 1'b0;
         ovf_reg     <= 1'b0;
         illegal_reg <= 1'b0;
      end else begin
         if (adv2) begin
            v2_reg      <= 1'b1;
            result_reg  <= result_next;
            zero_reg    <= (result_next == '0);
            ovf_reg     <= ovf_next;
            illegal_reg <= illegal_next;
         end else if (bus.out_ready) begin
            v2_reg <= 1'b0;
         end
      end
   end

   assign bus.out_valid = v2_reg;
   assign bus.result    = result_reg;
   assign bus.zero      = zero_reg;
   assign bus.ovf       = ovf_reg;
   assign bus.illegal   = illegal_reg;
endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed scenarios followed by a random
// stream, all checked against a scoreboard fed by an arithmetic reference model.
module tb_alu_exec;
   localparam int W = 32;

   logic clk;
   logic rst;

   alu_exec_if #(.WIDTH(W)) bus ();

   alu_exec #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [W-1:0] r;
      logic         z;
      logic         o;
      logic         il;
   } exp_t;

   exp_t         exp_q[$];
   logic [W-1:0] got_q[$];
   int           n_asserts = 0;
   int           n_fail    = 0;
   int           n_txn     = 0;
   bit           acc_flag  = 0;
   bit           hold_prev = 0;
   logic [W-1:0] held_r;
   logic         held_z, held_o, held_il;

   // Reference model built from signed integer arithmetic.
   function automatic exp_t model(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
      exp_t   e;
      longint sa, sb, full;
      longint max_v = 64'sd2147483647;
      longint min_v = -64'sd2147483648;
      sa   = $signed(a);
      sb   = $signed(b);
      e.r  = '0;
      e.o  = 1'b0;
      e.il = 1'b0;
      case (op)
         3'b010: begin full = sa + sb; e.r = full[W-1:0]; e.o = (full > max_v) || (full < min_v); end
         3'b110: begin full = sa - sb; e.r = full[W-1:0]; e.o = (full > max_v) || (full < min_v); end
         3'b000: e.r = a & b;
         3'b001: e.r = a | b;
         3'b111: e.r = (sa < sb) ? 32'd1 : 32'd0;
         default: e.il = 1'b1;
      endcase
      e.z = (e.r == 0);
      return e;
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
      n_asserts++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One clock cycle: sample handshakes away from the edge, score, advance.
   task automatic step();
      bit   rst_s;
      exp_t e;
      #1;
      rst_s    = rst;
      acc_flag = 0;
      if (hold_prev && !rst_s) begin
         chk("hold_valid", bus.out_valid, 1);
         chk("hold_result", bus.result, held_r);
         chk("hold_flags", {bus.zero, bus.ovf, bus.illegal}, {held_z, held_o, held_il});
      end
      if (!rst_s && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_output", bus.out_valid, 0);
         end else begin
            e = exp_q.pop_front();
            n_txn++;
            $display("txn %0d: result=%h zero=%b ovf=%b illegal=%b", n_txn,
                     bus.result, bus.zero, bus.ovf, bus.illegal);
            chk("sb_result", bus.result, e.r);
            chk("sb_flags", {bus.zero, bus.ovf, bus.illegal}, {e.z, e.o, e.il});
            got_q.push_back(bus.result);
         end
      end
      hold_prev = !rst_s && bus.out_valid && !bus.out_ready;
      held_r    = bus.result;
      held_z    = bus.zero;
      held_o    = bus.ovf;
      held_il   = bus.illegal;
      if (!rst_s && bus.in_valid && bus.in_ready) begin
         acc_flag = 1;
         exp_q.push_back(model(bus.aluoper, bus.srca, bus.srcb));
      end
      @(posedge clk);
      #1;
      if (rst_s) begin
         exp_q.delete();
         hold_prev = 0;
      end
   endtask

   task automatic drive(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
      bus.in_valid = 1'b1;
      bus.aluoper  = op;
      bus.srca     = a;
      bus.srcb     = b;
   endtask

   task automatic drain();
      int cnt = 0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      while ((exp_q.size() != 0 || bus.out_valid) && cnt < 50) begin
         step();
         cnt++;
      end
      chk("drain_empty", exp_q.size(), 0);
   endtask

   function automatic logic [W-1:0] rand_operand();
      logic [W-1:0] specials[5] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
      if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
      return $urandom;
   endfunction

   initial begin
      int waited;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.aluoper   = 3'b000;
      bus.srca      = '0;
      bus.srcb      = '0;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;

      // Reset state.
      step();
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_result", bus.result, 0);
      chk("rst_flags", {bus.zero, bus.ovf, bus.illegal}, 3'b000);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", bus.in_ready, 1);

      // Add overflow and two-cycle latency.
      bus.out_ready = 1'b1;
      drive(3'b010, 32'h7FFF_FFFF, 32'h0000_0001);
      step();
      bus.in_valid = 1'b0;
      chk("lat_after_accept", bus.out_valid, 0);
      step();
      chk("lat_valid", bus.out_valid, 1);
      chk("add_ovf_result", bus.result, 32'h8000_0000);
      chk("add_ovf_flags", {bus.zero, bus.ovf}, 2'b01);
      drain();

      // Sub to zero, then two slt back-to-back.
      drive(3'b110, 32'd5, 32'd5);
      step();
      drive(3'b111, 32'hFFFF_FFFF, 32'h0000_0001);
      step();
      chk("sub_zero_result", bus.result, 0);
      chk("sub_zero_flag", bus.zero, 1);
      drive(3'b111, 32'h8000_0000, 32'h0000_0001);
      step();
      chk("slt_neg1_result", bus.result, 1);
      bus.in_valid = 1'b0;
      step();
      chk("slt_min_result", bus.result, 1);
      chk("slt_min_ovf", bus.ovf, 0);
      drain();

      // Bitwise and/or.
      drive(3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
      step();
      drive(3'b001, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
      step();
      chk("and_result", bus.result, 32'h00F0_00F0);
      chk("and_ovf", bus.ovf, 0);
      bus.in_valid = 1'b0;
      step();
      chk("or_result", bus.result, 32'hFFF0_FFF0);
      chk("or_ovf", bus.ovf, 0);
      drain();

      // Back-pressure: four adds, out_ready low for five cycles.
      got_q.delete();
      bus.out_ready = 1'b0;
      drive(3'b010, 32'd1, 32'd1);
      step();
      drive(3'b010, 32'd2, 32'd2);
      step();
      chk("bp_full_in_ready", bus.in_ready, 0);
      drive(3'b010, 32'd3, 32'd3);
      step();
      step();
      step();
      chk("bp_held_result", bus.result, 2);
      chk("bp_still_full", bus.in_ready, 0);
      bus.out_ready = 1'b1;
      for (int k = 3; k <= 4; k++) begin
         drive(3'b010, k, k);
         waited = 0;
         do begin
            step();
            waited++;
         end while (!acc_flag && waited < 20);
         chk("bp_accept_timeout", acc_flag, 1);
      end
      drain();
      chk("bp_count", got_q.size(), 4);
      for (int k = 0; k < 4 && k < got_q.size(); k++)
         chk("bp_order", got_q[k], 2 * (k + 1));

      // Illegal op then a legal one.
      drive(3'b100, 32'd3, 32'd4);
      step();
      drive(3'b001, 32'd3, 32'd4);
      step();
      chk("illegal_result", bus.result, 0);
      chk("illegal_flags", {bus.zero, bus.illegal}, 2'b11);
      bus.in_valid = 1'b0;
      step();
      chk("legal_after_illegal", bus.illegal, 0);
      drain();

      // Random traffic with random back-pressure.
      bus.in_valid = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (!bus.in_valid || acc_flag) begin
            bus.aluoper = 3'($urandom_range(0, 7));
            bus.srca    = rand_operand();
            bus.srcb    = rand_operand();
         end
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.out_ready = ($urandom_range(0, 2) != 0);
         step();
      end
      drain();

      // Reset with two ops in flight under back-pressure.
      bus.out_ready = 1'b0;
      drive(3'b010, 32'd10, 32'd20);
      step();
      drive(3'b110, 32'd30, 32'd5);
      step();
      chk("inflight_full", bus.in_ready, 0);
      bus.in_valid = 1'b0;
      rst          = 1'b1;
      step();
      rst = 1'b0;
      chk("rst2_out_valid", bus.out_valid, 0);
      chk("rst2_result", bus.result, 0);
      chk("rst2_flags", {bus.zero, bus.ovf, bus.illegal}, 3'b000);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("rst2_no_output", bus.out_valid, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end
endmodule
